relu_pool2x2: RTL and testbench

- Downstream stage of the 3-channel convolution accumulator.
- Each conv_ack pulse delivers one output pixel. The block adds the R/G/B partial sums, applies ReLU with saturation, and performs 2x2 max pooling (stride 2) over a raster-ordered feature map.
- A half-width line buffer holds pair maxima from each even row until the odd row arrives.

---
 rtl/relu_pool2x2.sv | 211 +++++++++++++++++++++
 tb/tb_relu_pool2x2.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_pool2x2.sv
// ReLU with saturation followed by 2x2/stride-2 max pooling over a raster-ordered feature map.
// Optional per-pixel ReLU bypass is compiled in with `define RELU_POOL_BYPASS_EN.
module relu_pool2x2 #(
    parameter int DATA_W = 32,
    parameter int MAX_W  = 64,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [CNT_W-1:0]  map_w,
    input  logic [CNT_W-1:0]  map_h,
`ifdef RELU_POOL_BYPASS_EN
    input  logic              bypass,
`endif
    input  logic              conv_ack,
    input  logic [DATA_W-1:0] conv_r,
    input  logic [DATA_W-1:0] conv_g,
    input  logic [DATA_W-1:0] conv_b,
    output logic [DATA_W-1:0] pool_out,
    output logic              pool_valid,
    output logic              frame_done,
    output logic              cfg_err
);

    localparam int BUF_D = MAX_W / 2;
    localparam int IDX_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;

    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]  w_q;
    logic [CNT_W-1:0]  h_q;
    logic [CNT_W-1:0]  col;
    logic [CNT_W-1:0]  row;
    logic [DATA_W-1:0] pair;
    logic [DATA_W-1:0] line_buf [BUF_D];

    logic              byp;
    logic              accept;
    logic              take;
    logic              col_odd;
    logic              col_last;
    logic              row_last;
    logic [IDX_W-1:0]  buf_idx;
    logic              cfg_bad;

    logic signed [DATA_W+1:0] sum;
    logic [DATA_W-1:0] relu;
    logic [DATA_W-1:0] pm;
    logic [DATA_W-1:0] line_val;
    logic [DATA_W-1:0] win_max;

    logic              buf_we;
    logic              pool_fire;
    logic              frame_fire;

`ifdef RELU_POOL_BYPASS_EN
    assign byp = bypass;
`else
    assign byp = 1'b0;
`endif

    // clear has priority over a coincident pixel, which is dropped.
    assign accept   = conv_ack & ~clear & ~cfg_err;
    assign take     = accept & ~byp;

    assign col_odd  = col[0];
    assign col_last = (col == w_q - CNT_W'(1));
    assign row_last = (row == h_q - CNT_W'(1));
    assign buf_idx  = IDX_W'(col >> 1);

    assign cfg_bad  = map_w[0] | map_h[0]
                    | (map_w < CNT_W'(2)) | (map_h < CNT_W'(2))
                    | (map_w > CNT_W'(MAX_W));

    // Two guard bits make the three-way sum of signed inputs overflow-free.
    assign sum = $signed({{2{conv_r[DATA_W-1]}}, conv_r})
               + $signed({{2{conv_g[DATA_W-1]}}, conv_g})
               + $signed({{2{conv_b[DATA_W-1]}}, conv_b});

    localparam logic signed [DATA_W+1:0] SAT = {3'b000, {(DATA_W-1){1'b1}}};

    always_comb begin
        if (sum[DATA_W+1]) begin
            relu = '0;
        end else if (sum > SAT) begin
            relu = {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            relu = sum[DATA_W-1:0];
        end
    end

    // Values are non-negative after ReLU, so unsigned compares give the max.
    assign pm       = (relu > pair) ? relu : pair;
    assign line_val = line_buf[buf_idx];
    assign win_max  = (pm > line_val) ? pm : line_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EVEN;
        end else if (clear) begin
            state <= S_EVEN;
        end else begin
            // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next = state;
        buf_we     = 1'b0;
        pool_fire  = 1'b0;
        frame_fire = 1'b0;
        if (take) begin
            case (state)
                S_EVEN: begin
                    if (col_odd) begin
                        buf_we = 1'b1;
                    end
                    if (col_last) begin
                        state_next = S_ODD;
                    end
                end
                S_ODD: begin
                    if (col_odd) begin
                        pool_fire  = 1'b1;
                        frame_fire = col_last & row_last;
                    end
                    if (col_last) begin
                        state_next = S_EVEN;
                    end
                end
                default: state_next = S_EVEN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q     <= '0;
            h_q     <= '0;
            cfg_err <= 1'b1;
        end else if (clear) begin
            w_q     <= map_w;
            h_q     <= map_h;
            cfg_err <= cfg_bad;
        end
    end

    // The final pixel of a frame wraps both counters so the next frame needs no clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (take) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair <= '0;
        end else if (clear) begin
            pair <= '0;
        end else if (take && !col_odd) begin
            pair <= relu;
        end
    end

    // NOTE: the line buffer has no reset; each entry is written on an even row before any odd row reads it.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[buf_idx] <= pm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pool_out   <= '0;
            pool_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pool_valid <= 1'b0;
            frame_done <= 1'b0;
            if (accept && byp) begin
                pool_out   <= relu;
                pool_valid <= 1'b1;
            end else if (pool_fire) begin
                pool_out   <= win_max;
                pool_valid <= 1'b1;
                frame_done <= frame_fire;
            end
        end
    end

endmodule

// File: tb/tb_relu_pool2x2.sv
// Self-checking bench for relu_pool2x2: directed cases plus randomized frames
// compared every cycle against a frame-array reference model.
module tb_relu_pool2x2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [9:0]  map_w = '0;
    logic [9:0]  map_h = '0;
    logic        conv_ack = 1'b0;
    logic [31:0] conv_r = '0;
    logic [31:0] conv_g = '0;
    logic [31:0] conv_b = '0;
    logic [31:0] pool_out;
    logic        pool_valid;
    logic        frame_done;
    logic        cfg_err;
    logic        byp = 1'b0;

    relu_pool2x2 #(.DATA_W(32), .MAX_W(64), .CNT_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .map_w      (map_w),
        .map_h      (map_h),
`ifdef RELU_POOL_BYPASS_EN
        .bypass     (byp),
`endif
        .conv_ack   (conv_ack),
        .conv_r     (conv_r),
        .conv_g     (conv_g),
        .conv_b     (conv_b),
        .pool_out   (pool_out),
        .pool_valid (pool_valid),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: whole-frame array of ReLU values, pooled by window.
    int          m_w = 0;
    int          m_h = 0;
    bit          m_err = 1'b1;
    int          m_r = 0;
    int          m_c = 0;
    logic [31:0] fm [0:7][0:63];
    logic [31:0] m_out = '0;
    bit          exp_valid;
    bit          exp_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] relu_ref(input logic [31:0] r, input logic [31:0] g,
                                             input logic [31:0] b);
        longint s;
        s = longint'($signed(r)) + longint'($signed(g)) + longint'($signed(b));
        if (s < 0) return 32'd0;
        if (s > 64'sd2147483647) return 32'h7fff_ffff;
        return 32'(s);
    endfunction

    function automatic logic [31:0] max2(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_w = 0; m_h = 0; m_err = 1'b1; m_r = 0; m_c = 0; m_out = '0;
    endtask

    task automatic check_outputs();
        check("pool_valid", 64'(pool_valid), 64'(exp_valid));
        check("frame_done", 64'(frame_done), 64'(exp_done));
        check("pool_out", 64'(pool_out), 64'(m_out));
        check("cfg_err", 64'(cfg_err), 64'(m_err));
    endtask

    // One clock: drive at negedge, sample 1 ns after the rising edge.
    task automatic step(input bit ack, input bit clr, input logic [31:0] r,
                        input logic [31:0] g, input logic [31:0] b);
        logic [31:0] v;
        @(negedge clk);
        conv_ack = ack; clear = clr; conv_r = r; conv_g = g; conv_b = b;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (clr) begin
            m_w = int'(map_w); m_h = int'(map_h);
            m_err = (m_w % 2 != 0) || (m_h % 2 != 0) || (m_w < 2) || (m_h < 2) || (m_w > 64);
            m_r = 0; m_c = 0;
        end else if (ack && !m_err) begin
            v = relu_ref(r, g, b);
            if (byp) begin
                m_out = v;
                exp_valid = 1'b1;
            end else begin
                fm[m_r][m_c] = v;
                if ((m_r % 2 == 1) && (m_c % 2 == 1)) begin
                    m_out = max2(max2(fm[m_r-1][m_c-1], fm[m_r-1][m_c]),
                                 max2(fm[m_r][m_c-1], v));
                    exp_valid = 1'b1;
                    exp_done  = (m_r == m_h - 1) && (m_c == m_w - 1);
                end
                m_c++;
                if (m_c == m_w) begin
                    m_c = 0;
                    m_r++;
                    if (m_r == m_h) m_r = 0;
                end
            end
        end
        check_outputs();
    endtask

    task automatic px(input int val);
        step(1'b1, 1'b0, 32'(val), 32'd0, 32'd0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic configure(input int w, input int h);
        map_w = 10'(w);
        map_h = 10'(h);
        step(1'b0, 1'b1, '0, '0, '0);
    endtask

    initial begin
        int w_sel [6];
        int h_sel [4];
        int w, h, npix, sent;
        logic [31:0] rv [3];
        w_sel = '{2, 4, 6, 8, 64, 3};
        h_sel = '{2, 4, 6, 8};

        // Reset values
        #12;
        check("rst_pool_out", 64'(pool_out), 64'd0);
        check("rst_pool_valid", 64'(pool_valid), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd1);
        rst = 1'b0;
        model_reset();

        // Unconfigured block ignores pixels
        px(7); px(8);

        // Basic 4x2 map: expect 9 then 7 with frame_done on the 7
        configure(4, 2);
        px(5); px(-3); px(7); px(2);
        px(1); px(9);
        check("basic_first", 64'(pool_out), 64'd9);
        px(-4); px(0);
        check("basic_second", 64'(pool_out), 64'd7);
        check("basic_done", 64'(frame_done), 64'd1);
        idle();
        check("basic_hold", 64'(pool_out), 64'd7);

        // Saturation on a 2x2 map
        configure(2, 2);
        repeat (4) step(1'b1, 1'b0, 32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff);
        check("sat_pos", 64'(pool_out), 64'h7fff_ffff);
        repeat (4) step(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        check("sat_neg", 64'(pool_out), 64'd0);

        // Three back-to-back 4x4 frames, no clear between them
        configure(4, 4);
        repeat (3) begin
            for (int k = 0; k < 16; k++) px(k);
        end
        check("b2b_last", 64'(pool_out), 64'd15);
        idle();

        // Clear with the 3rd ack drops that pixel, then a 2x2 frame gives 4
        configure(2, 2);
        px(50); px(60);
        map_w = 10'd2; map_h = 10'd2;
        step(1'b1, 1'b1, 32'd99, 32'd0, 32'd0);
        px(1); px(2); px(3); px(4);
        check("clear_drop", 64'(pool_out), 64'd4);
        idle();

        // Illegal widths, then recovery
        configure(3, 2);
        px(1); px(2); px(3); px(4); px(5); px(6);
        configure(66, 2);
        px(1); px(2);
        configure(0, 2);
        px(1);
        configure(2, 2);
        check("cfg_recover", 64'(cfg_err), 64'd0);
        px(3); px(1); px(-2); px(2);

`ifdef RELU_POOL_BYPASS_EN
        // Bypass leaves counters where they were
        configure(2, 2);
        px(10);
        byp = 1'b1;
        px(-5);
        check("byp_neg", 64'(pool_out), 64'd0);
        px(12);
        check("byp_pos", 64'(pool_out), 64'd12);
        byp = 1'b0;
        px(1); px(20); px(3);
        check("byp_resume", 64'(pool_out), 64'd20);
`endif

        // Randomized frames with gaps and occasional mid-frame clears
        for (int f = 0; f < 24; f++) begin
            w = w_sel[$urandom_range(0, 5)];
            h = h_sel[$urandom_range(0, 3)];
            if (w == 64) h = 2;
            configure(w, h);
            npix = m_err ? 6 : w * h;
            sent = 0;
            while (sent < npix) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle();
                end else if ($urandom_range(0, 60) == 0) begin
                    step(1'b1, 1'b1, 32'd5, 32'd5, 32'd5);
                    sent = 0;
                end else begin
                    for (int c = 0; c < 3; c++) begin
                        if ($urandom_range(0, 3) == 0) rv[c] = $urandom;
                        else rv[c] = 32'($urandom_range(0, 2000)) - 32'd1000;
                    end
                    step(1'b1, 1'b0, rv[0], rv[1], rv[2]);
                    sent++;
                end
            end
        end

        // Asynchronous reset in the middle of a frame
        configure(4, 4);
        px(100); px(200); px(300); px(400); px(500);
        @(negedge clk);
        conv_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_pool_out", 64'(pool_out), 64'd0);
        check("arst_pool_valid", 64'(pool_valid), 64'd0);
        check("arst_cfg_err", 64'(cfg_err), 64'd1);
        #1 rst = 1'b0;
        px(1); px(2);
        configure(2, 2);
        px(8); px(1); px(2); px(3);
        check("arst_recover", 64'(pool_out), 64'd8);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
